// File: rtl/matrix_datapath_pkg.sv
// Shared constants and types for the matrix datapath: geometry, opcodes, ALU selects.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matrix_datapath_pkg;

  localparam int WIDTH_BIT = 2;
  localparam int INDEX_BIT = 3;
  localparam int INSTR_BIT = 8;
  localparam int WIDTH     = 2**WIDTH_BIT;

  // Opcodes in instruction[31:29]
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_R       = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_MULI    = 3'b011;
  localparam logic [2:0] OP_LI      = 3'b100;
  localparam logic [2:0] OP_JUMP    = 3'b101;
  localparam logic [2:0] OP_HALT    = 3'b110;
  localparam logic [2:0] OP_NOP_ALT = 3'b111;

  // ALU operation selects
  localparam logic [2:0] SEL_ADD    = 3'b000;
  localparam logic [2:0] SEL_SUB    = 3'b001;
  localparam logic [2:0] SEL_MUL    = 3'b010;
  localparam logic [2:0] SEL_MATMUL = 3'b011;
  localparam logic [2:0] SEL_TRANS  = 3'b100;
  localparam logic [2:0] SEL_PASS2  = 3'b101;
  localparam logic [2:0] SEL_AND    = 3'b110;
  localparam logic [2:0] SEL_PASS1  = 3'b111;

  // Row-major matrix, element (0,0) occupies the most significant word
  typedef logic [0:WIDTH-1][0:WIDTH-1][31:0] matrix_t;

endpackage

// File: rtl/matrix_datapath_alu.sv
// Combinational matrix ALU: elementwise add/sub/mul/and, matrix multiply, transpose, pass-through.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output always reflects the current operands.
module matrix_alu
  import matrix_datapath_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]                  sel,
  input  logic [WIDTH*WIDTH*32-1:0]   data1,
  input  logic [WIDTH*WIDTH*32-1:0]   data2,
  output logic [WIDTH*WIDTH*32-1:0]   result
);

  typedef logic [0:WIDTH-1][0:WIDTH-1][31:0] mat_t;

  mat_t        a;
  mat_t        b;
  mat_t        y;
  logic [31:0] acc;

  assign a      = data1;
  assign b      = data2;
  assign result = y;

  // Evaluate the selected operation for every output element; dot products wrap mod 2^32
  always_comb begin
    y   = '0;
    acc = '0;
    for (int r = 0; r < WIDTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        acc = '0;
        for (int k = 0; k < WIDTH; k++) begin
          acc = acc + a[r][k] * b[k][c];
        end
        case (sel)
          SEL_ADD:    y[r][c] = a[r][c] + b[r][c];
          SEL_SUB:    y[r][c] = a[r][c] - b[r][c];
          SEL_MUL:    y[r][c] = a[r][c] * b[r][c];
          SEL_MATMUL: y[r][c] = acc;
          SEL_TRANS:  y[r][c] = a[c][r];
          SEL_PASS2:  y[r][c] = b[r][c];
          SEL_AND:    y[r][c] = a[r][c] & b[r][c];
          default:    y[r][c] = a[r][c];
        endcase
      end
    end
  end

endmodule

// File: rtl/matrix_datapath.sv
// Matrix datapath: instruction decode, 2R/1W matrix register file, combinational matrix ALU.
// Latency: outputs combinational from instruction; register write-back lands on the next CLK edge.
// Backpressure: none; enable low suppresses the write-back while outputs keep tracking instruction.
module matrix_datapath
  import matrix_datapath_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  input  logic [31:0]                instruction,
  output logic                       PC_src,
  output logic [INSTR_BIT-1:0]       jump_addr,
  output logic                       done,
  output logic [WIDTH*WIDTH*32-1:0]  result
);

  localparam int NUM_REGS = 2**INDEX_BIT;
  localparam int IMM_BIT  = 29 - 2*INDEX_BIT;

  logic [2:0]           op;
  logic [INDEX_BIT-1:0] wr_idx;
  logic [INDEX_BIT-1:0] r1_idx;
  logic [INDEX_BIT-1:0] r2_idx;
  logic [2:0]           sel_field;
  logic [31:0]          imm;
  logic                 write_enable;
  logic                 generated_enable;
  logic [2:0]           alu_sel;

  matrix_t data1;
  matrix_t data2;
  matrix_t alu_res;

  matrix_t regs_q [NUM_REGS];
  matrix_t regs_d [NUM_REGS];

  // Decode fields and control strobes straight from the instruction word
  always_comb begin
    op               = instruction[31:29];
    wr_idx           = instruction[28 -: INDEX_BIT];
    r1_idx           = instruction[28-INDEX_BIT -: INDEX_BIT];
    r2_idx           = instruction[28-2*INDEX_BIT -: INDEX_BIT];
    sel_field        = instruction[2:0];
    imm              = {{(32-IMM_BIT){instruction[IMM_BIT-1]}}, instruction[IMM_BIT-1:0]};
    write_enable     = 1'b0;
    generated_enable = 1'b0;
    alu_sel          = sel_field;
    case (op)
      OP_R: begin
        write_enable = 1'b1;
      end
      OP_ADDI: begin
        write_enable     = 1'b1;
        generated_enable = 1'b1;
        alu_sel          = SEL_ADD;
      end
      OP_MULI: begin
        write_enable     = 1'b1;
        generated_enable = 1'b1;
        alu_sel          = SEL_MUL;
      end
      OP_LI: begin
        write_enable     = 1'b1;
        generated_enable = 1'b1;
        alu_sel          = SEL_PASS2;
      end
      OP_NOP, OP_JUMP, OP_HALT, OP_NOP_ALT: begin
      end
      default: begin
      end
    endcase
    PC_src    = (op == OP_JUMP);
    done      = (op == OP_HALT);
    jump_addr = instruction[INSTR_BIT-1:0];
  end

  // Operand fetch; immediate forms broadcast the constant and ignore the r2 field
  always_comb begin
    data1 = regs_q[r1_idx];
    data2 = generated_enable ? matrix_t'({(WIDTH*WIDTH){imm}}) : regs_q[r2_idx];
  end

  matrix_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .sel    (alu_sel),
    .data1  (data1),
    .data2  (data2),
    .result (alu_res)
  );

  assign result = alu_res;

  // Next register-file state: write-back only when decoded as a writer and enabled
  always_comb begin
    regs_d = regs_q;
    if (write_enable && enable) begin
      regs_d[wr_idx] = alu_res;
    end
  end

  // Register file state; reset clears every matrix asynchronously and wins over a write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_matrix_datapath.sv
// Self-checking bench for matrix_datapath: directed scenarios plus randomized instructions vs a reference model.
// Latency: checks combinational outputs mid-cycle, register contents the cycle after write-back.
// Backpressure: n/a.
module tb_matrix_datapath;

  localparam int W  = 4;
  localparam int NR = 8;
  localparam int MW = W*W*32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          enable;
  logic [31:0]   instruction;
  logic          PC_src;
  logic [7:0]    jump_addr;
  logic          done;
  logic [MW-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference register file: NR matrices of W x W words
  logic [31:0] mreg [NR][W][W];

  matrix_datapath dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .instruction (instruction),
    .PC_src      (PC_src),
    .jump_addr   (jump_addr),
    .done        (done),
    .result      (result)
  );

  always #10 CLK = ~CLK;

  function automatic logic [31:0] enc_r(input logic [2:0] wr, input logic [2:0] r1,
                                        input logic [2:0] r2, input logic [2:0] sel);
    return {3'b001, wr, r1, r2, 17'b0, sel};
  endfunction

  function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [2:0] wr,
                                        input logic [2:0] r1, input int k);
    logic [31:0] kv;
    kv = k;
    return {op, wr, r1, kv[22:0]};
  endfunction

  // Pass-data1 read of a register; used with enable low so nothing is written
  function automatic logic [31:0] rd(input logic [2:0] idx);
    return enc_r(3'd0, idx, 3'd0, 3'b111);
  endfunction

  function automatic logic [MW-1:0] bcast(input logic [31:0] v);
    return {(W*W){v}};
  endfunction

  function automatic logic [31:0] elem(input logic [MW-1:0] m, input int r, input int c);
    return m[MW-1-32*(r*W+c) -: 32];
  endfunction

  function automatic logic [MW-1:0] model_reg(input int idx);
    logic [MW-1:0] out;
    out = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        out[MW-1-32*(r*W+c) -: 32] = mreg[idx][r][c];
    return out;
  endfunction

  // Expected ALU output, computed element by element from the instruction semantics
  function automatic logic [MW-1:0] model_result(input logic [31:0] ins);
    logic [MW-1:0] out;
    logic [31:0]   a [W][W];
    logic [31:0]   b [W][W];
    logic [31:0]   y;
    int op, r1, r2, sel, k;
    op  = int'(ins[31:29]);
    r1  = int'(ins[25:23]);
    r2  = int'(ins[22:20]);
    sel = int'(ins[2:0]);
    k   = $signed(ins[22:0]);
    if (op == 2) sel = 0;
    if (op == 3) sel = 2;
    if (op == 4) sel = 5;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        a[r][c] = mreg[r1][r][c];
        b[r][c] = (op >= 2 && op <= 4) ? 32'(k) : mreg[r2][r][c];
      end
    out = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        case (sel)
          0: y = a[r][c] + b[r][c];
          1: y = a[r][c] - b[r][c];
          2: y = a[r][c] * b[r][c];
          3: begin
            y = 0;
            for (int i = 0; i < W; i++) y = y + a[r][i] * b[i][c];
          end
          4: y = a[c][r];
          5: y = b[r][c];
          6: y = a[r][c] & b[r][c];
          default: y = a[r][c];
        endcase
        out[MW-1-32*(r*W+c) -: 32] = y;
      end
    return out;
  endfunction

  function automatic bit is_writer(input logic [31:0] ins);
    return (ins[31:29] >= 3'd1) && (ins[31:29] <= 3'd4);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++)
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          mreg[i][r][c] = '0;
  endtask

  // Present an instruction just after a rising edge and wait to mid-cycle
  task automatic apply(input logic [31:0] ins, input logic en);
    instruction = ins;
    enable      = en;
    @(negedge CLK);
  endtask

  // Take the rising edge and mirror any write-back in the model
  task automatic clock_in();
    logic [MW-1:0] exp;
    logic [31:0]   ins;
    logic          en;
    ins = instruction;
    en  = enable;
    exp = model_result(ins);
    @(posedge CLK);
    if (en && is_writer(ins))
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          mreg[int'(ins[28:26])][r][c] = exp[MW-1-32*(r*W+c) -: 32];
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; instruction = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_clear();
    for (int i = 0; i < NR; i++) begin
      apply(rd(3'(i)), 1'b0);
      n_checks++;
      if (result !== '0) $display("FAIL reset_reg%0d got=%h exp=0", i, result);
      else n_pass++;
      clock_in();
    end
    apply(32'h0, 1'b1);
    n_checks++;
    if (PC_src !== 1'b0 || done !== 1'b0) $display("FAIL nop_ctrl got pc=%b done=%b exp 0 0", PC_src, done);
    else n_pass++;
    clock_in();
  endtask

  task automatic test_li();
    apply(enc_i(3'b100, 3'd1, 3'd0, 5), 1'b1);
    n_checks++;
    if (result !== bcast(32'd5)) $display("FAIL li_comb got=%h exp=%h", result, bcast(32'd5));
    else n_pass++;
    clock_in();
    apply(rd(3'd1), 1'b0);
    n_checks++;
    if (result !== bcast(32'd5)) $display("FAIL li_m1 got=%h exp=%h", result, bcast(32'd5));
    else n_pass++;
    clock_in();
  endtask

  task automatic test_neg_imm();
    apply(enc_i(3'b100, 3'd2, 3'd0, -3), 1'b1);
    clock_in();
    apply(rd(3'd2), 1'b0);
    n_checks++;
    if (result !== bcast(32'hFFFF_FFFD)) $display("FAIL neg_imm got=%h exp=%h", result, bcast(32'hFFFF_FFFD));
    else n_pass++;
    clock_in();
  endtask

  task automatic test_add_matmul();
    apply(enc_r(3'd3, 3'd1, 3'd2, 3'b000), 1'b1);
    clock_in();
    apply(rd(3'd3), 1'b0);
    n_checks++;
    if (result !== bcast(32'd2)) $display("FAIL add got=%h exp=%h", result, bcast(32'd2));
    else n_pass++;
    clock_in();
    apply(enc_r(3'd4, 3'd1, 3'd1, 3'b011), 1'b1);
    clock_in();
    apply(rd(3'd4), 1'b0);
    n_checks++;
    if (result !== bcast(32'd100)) $display("FAIL matmul got=%h exp=%h", result, bcast(32'd100));
    else n_pass++;
    clock_in();
  endtask

  task automatic test_transpose();
    apply(enc_i(3'b100, 3'd5, 3'd0, 7), 1'b1);
    clock_in();
    apply(enc_r(3'd6, 3'd5, 3'd0, 3'b100), 1'b1);
    clock_in();
    apply(rd(3'd6), 1'b0);
    n_checks++;
    if (elem(result, 1, 0) !== 32'd7) $display("FAIL transpose_m6_10 got=%h exp=7", elem(result, 1, 0));
    else n_pass++;
    n_checks++;
    if (result !== model_reg(6)) $display("FAIL transpose_m6 got=%h exp=%h", result, model_reg(6));
    else n_pass++;
    clock_in();
  endtask

  task automatic test_control();
    apply({3'b101, 3'd1, 18'h0, 8'h2A}, 1'b1);
    n_checks++;
    if (PC_src !== 1'b1 || jump_addr !== 8'h2A || done !== 1'b0)
      $display("FAIL jump got pc=%b addr=%h done=%b exp 1 2a 0", PC_src, jump_addr, done);
    else n_pass++;
    clock_in();
    apply(rd(3'd1), 1'b0);
    n_checks++;
    if (result !== bcast(32'd5)) $display("FAIL jump_nowrite got=%h exp=%h", result, bcast(32'd5));
    else n_pass++;
    clock_in();
    apply({3'b110, 29'h0}, 1'b1);
    n_checks++;
    if (done !== 1'b1 || PC_src !== 1'b0) $display("FAIL halt got done=%b pc=%b exp 1 0", done, PC_src);
    else n_pass++;
    clock_in();
  endtask

  task automatic test_enable_low();
    apply(enc_i(3'b010, 3'd1, 3'd1, 10), 1'b0);
    n_checks++;
    if (result !== bcast(32'd15)) $display("FAIL en_low_comb got=%h exp=%h", result, bcast(32'd15));
    else n_pass++;
    clock_in();
    apply(rd(3'd1), 1'b0);
    n_checks++;
    if (result !== bcast(32'd5)) $display("FAIL en_low_hold got=%h exp=%h", result, bcast(32'd5));
    else n_pass++;
    clock_in();
  endtask

  task automatic test_wrap();
    apply(enc_i(3'b100, 3'd7, 3'd0, -1), 1'b1);
    clock_in();
    apply(enc_i(3'b010, 3'd7, 3'd7, 1), 1'b1);
    clock_in();
    apply(rd(3'd7), 1'b0);
    n_checks++;
    if (result !== '0) $display("FAIL wrap got=%h exp=0", result);
    else n_pass++;
    clock_in();
  endtask

  task automatic test_random();
    logic [31:0]   rv;
    logic [2:0]    op;
    logic [31:0]   ins;
    logic          en;
    logic [MW-1:0] exp;
    for (int n = 0; n < 300; n++) begin
      rv  = $urandom;
      op  = 3'($urandom_range(0, 7));
      ins = {op, rv[28:0]};
      en  = 1'($urandom_range(0, 1));
      apply(ins, en);
      exp = model_result(ins);
      n_checks++;
      if (PC_src !== (op == 3'b101)) $display("FAIL rnd_pc n=%0d got=%b ins=%h", n, PC_src, ins);
      else n_pass++;
      n_checks++;
      if (done !== (op == 3'b110)) $display("FAIL rnd_done n=%0d got=%b ins=%h", n, done, ins);
      else n_pass++;
      n_checks++;
      if (jump_addr !== ins[7:0]) $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, jump_addr, ins[7:0]);
      else n_pass++;
      if (is_writer(ins)) begin
        n_checks++;
        if (result !== exp) $display("FAIL rnd_result n=%0d ins=%h got=%h exp=%h", n, ins, result, exp);
        else n_pass++;
      end
      clock_in();
    end
    for (int i = 0; i < NR; i++) begin
      apply(rd(3'(i)), 1'b0);
      n_checks++;
      if (result !== model_reg(i)) $display("FAIL rnd_reg%0d got=%h exp=%h", i, result, model_reg(i));
      else n_pass++;
      clock_in();
    end
  endtask

  task automatic test_async_reset();
    apply(enc_i(3'b100, 3'd3, 3'd0, 11), 1'b1);
    clock_in();
    // Mid low phase: raise reset with no clock edge, then sweep all registers
    @(negedge CLK);
    #1 RST = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < NR; i++) begin
      instruction = rd(3'(i));
      #1;
      n_checks++;
      if (result !== '0) $display("FAIL async_rst_reg%0d got=%h exp=0", i, result);
      else n_pass++;
    end
    model_clear();
    // Reset held across an edge with a pending write: reset must win
    instruction = enc_i(3'b100, 3'd3, 3'd0, 9);
    enable      = 1'b1;
    @(posedge CLK);
    #1;
    instruction = rd(3'd3);
    enable      = 1'b0;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL rst_priority got=%h exp=0", result);
    else n_pass++;
    RST = 1'b0;
    apply(enc_i(3'b100, 3'd3, 3'd0, 9), 1'b1);
    clock_in();
    apply(rd(3'd3), 1'b0);
    n_checks++;
    if (result !== bcast(32'd9)) $display("FAIL post_rst_li got=%h exp=%h", result, bcast(32'd9));
    else n_pass++;
    clock_in();
  endtask

  initial begin
    test_reset();
    test_li();
    test_neg_imm();
    test_add_matmul();
    test_transpose();
    test_control();
    test_enable_low();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
